exec_sequencer: RTL and testbench

- Parametrised successor to the cpu's control unit and instruction pointer, merged into one synchronous block.
- Runs the multi-cycle fetch/decode/execute sequence and emits one-hot step strobes to the fetcher, reg_stack, alu and ports.
- Owns the instruction pointer and implements JMP and conditional BR.
- Adds ack handshakes with a wait timeout, HALT, and a sticky fault state for illegal opcodes or timeouts.

---
 rtl/exec_sequencer_pkg.sv | 58 +++++
 rtl/exec_sequencer_pointer.sv | 47 ++++
 rtl/exec_sequencer.sv | 169 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared constants for the execution sequencer: opcodes, default widths,
// state encoding and the state-to-strobe decode.
package exec_sequencer_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int NIB_SIZE_DEF  = 4;
    localparam int BYTE_SIZE_DEF = 8;

    localparam logic [3:0] OP_LOADLO = 4'h1;
    localparam logic [3:0] OP_JMP    = 4'h2;
    localparam logic [3:0] OP_BR     = 4'h3;
    localparam logic [3:0] OP_IN     = 4'h4;
    localparam logic [3:0] OP_OUT    = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_REGLOAD  = 4'd2;
    localparam logic [3:0] ST_ALUOP    = 4'd3;
    localparam logic [3:0] ST_MEMLOAD  = 4'd4;
    localparam logic [3:0] ST_MEMSTORE = 4'd5;
    localparam logic [3:0] ST_REGSTORE = 4'd6;
    localparam logic [3:0] ST_NEXT     = 4'd7;
    localparam logic [3:0] ST_HALT     = 4'd8;
    localparam logic [3:0] ST_FAULT    = 4'd9;

    typedef struct packed {
        logic fetch;
        logic regload;
        logic aluop;
        logic memload;
        logic memstore;
        logic regstore;
        logic next;
    } strobes_t;

    // One-hot step strobe for each state; IDLE, HALT and FAULT drive none.
    function automatic strobes_t decode_strobes(input logic [3:0] st);
        strobes_t s;
        s = '{default: 1'b0};
        case (st)
            ST_FETCH:    s.fetch    = 1'b1;
            ST_REGLOAD:  s.regload  = 1'b1;
            ST_ALUOP:    s.aluop    = 1'b1;
            ST_MEMLOAD:  s.memload  = 1'b1;
            ST_MEMSTORE: s.memstore = 1'b1;
            ST_REGSTORE: s.regstore = 1'b1;
            ST_NEXT:     s.next     = 1'b1;
            default:     s = '{default: 1'b0};
        endcase
        return s;
    endfunction

    function automatic int wait_width(input int max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/exec_sequencer_pointer.sv
// Instruction pointer: reset-vector load and relative update (+1 or a
// sign-extended signed offset), wrapping modulo 2^ADDR_WIDTH.
module seq_pointer #(
    parameter int ADDR_WIDTH   = 16,
    parameter int BYTE_SIZE    = 8,
    parameter int RESET_VECTOR = 0
) (
    input  logic                  clk,
    input  logic                  do_reset,
    input  logic                  advance_i,
    input  logic                  use_offset_i,
    input  logic [BYTE_SIZE-1:0]  offset_i,
    output logic [ADDR_WIDTH-1:0] pointer_o
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [ADDR_WIDTH-1:0] offset_ext_s;
    logic [ADDR_WIDTH-1:0] adj_s;

    // Select the step and form the wrapped next pointer.
    always_comb begin
        offset_ext_s = ADDR_WIDTH'($signed(offset_i));
        if (use_offset_i) begin
            adj_s = offset_ext_s;
        end else begin
            adj_s = ADDR_WIDTH'(1);
        end
        if (advance_i) begin
            ptr_d = ptr_q + adj_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous reset to the reset vector.
    always_ff @(posedge clk) begin
        if (do_reset) begin
            ptr_q <= ADDR_WIDTH'(RESET_VECTOR);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pointer_o = ptr_q;

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute sequencer: Moore FSM with registered one-hot step
// strobes, ack waits with timeout, HALT and sticky FAULT.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int BYTE_SIZE    = BYTE_SIZE_DEF,
    parameter int RESET_VECTOR = 0,
    parameter int MAX_WAIT     = 15
) (
    input  logic                  clk,
    input  logic                  do_reset,
    input  logic [3:0]            opcode,
    input  logic                  isaluop,
    input  logic [BYTE_SIZE-1:0]  bigval,
    input  logic [WORD_SIZE-1:0]  cond_val,
    input  logic                  fetch_ack,
    input  logic                  port_ack,
    output logic [ADDR_WIDTH-1:0] pointer,
    output logic                  do_fetch,
    output logic                  do_regload,
    output logic                  do_aluop,
    output logic                  do_memload,
    output logic                  do_memstore,
    output logic                  do_regstore,
    output logic                  do_next,
    output logic                  halted,
    output logic                  fault
);

    localparam int WAIT_W = wait_width(MAX_WAIT);

    logic [3:0]           state_q, state_d;
    logic [WAIT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic                 isalu_q, isalu_d;
    logic [BYTE_SIZE-1:0] bigval_q, bigval_d;
    strobes_t             strobes_q;
    logic                 halted_q, fault_q;
    logic                 wait_expired_s;
    logic                 use_offset_s;
    logic                 advance_s;

    assign wait_expired_s = (MAX_WAIT > 0) && (cnt_q == WAIT_W'(MAX_WAIT));

    // Next-state, wait counter and instruction latch logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = {WAIT_W{1'b0}};
        op_d     = op_q;
        isalu_d  = isalu_q;
        bigval_d = bigval_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_ack) begin
                    op_d     = opcode;
                    isalu_d  = isaluop;
                    bigval_d = bigval;
                    if (isaluop) begin
                        state_d = ST_REGLOAD;
                    end else begin
                        case (opcode)
                            OP_LOADLO: state_d = ST_REGSTORE;
                            OP_IN:     state_d = ST_REGLOAD;
                            OP_OUT:    state_d = ST_REGLOAD;
                            OP_JMP:    state_d = ST_NEXT;
                            OP_BR:     state_d = ST_REGLOAD;
                            OP_HALT:   state_d = ST_HALT;
                            default:   state_d = ST_FAULT;
                        endcase
                    end
                end else if (wait_expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            ST_REGLOAD: begin
                if (isalu_q) begin
                    state_d = ST_ALUOP;
                end else begin
                    case (op_q)
                        OP_IN:   state_d = ST_MEMLOAD;
                        OP_OUT:  state_d = ST_MEMSTORE;
                        OP_BR:   state_d = ST_NEXT;
                        default: state_d = ST_FAULT;
                    endcase
                end
            end
            ST_ALUOP: state_d = ST_REGSTORE;
            ST_MEMLOAD: begin
                if (port_ack) begin
                    state_d = ST_REGSTORE;
                end else if (wait_expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            ST_MEMSTORE: begin
                if (port_ack) begin
                    state_d = ST_NEXT;
                end else if (wait_expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            ST_REGSTORE: state_d = ST_NEXT;
            ST_NEXT:     state_d = ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
            ST_FAULT:    state_d = ST_FAULT;
            default:     state_d = ST_FAULT;
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (do_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {WAIT_W{1'b0}};
            op_q      <= 4'h0;
            isalu_q   <= 1'b0;
            bigval_q  <= {BYTE_SIZE{1'b0}};
            strobes_q <= '{default: 1'b0};
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            isalu_q   <= isalu_d;
            bigval_q  <= bigval_d;
            strobes_q <= decode_strobes(state_d);
            halted_q  <= (state_d == ST_HALT);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    // BR condition is sampled live during NEXT; ALU-class words never jump.
    assign advance_s    = (state_q == ST_NEXT);
    assign use_offset_s = !isalu_q && ((op_q == OP_JMP) || ((op_q == OP_BR) && (|cond_val)));

    seq_pointer #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BYTE_SIZE    (BYTE_SIZE),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pointer (
        .clk          (clk),
        .do_reset     (do_reset),
        .advance_i    (advance_s),
        .use_offset_i (use_offset_s),
        .offset_i     (bigval_q),
        .pointer_o    (pointer)
    );

    assign do_fetch    = strobes_q.fetch;
    assign do_regload  = strobes_q.regload;
    assign do_aluop    = strobes_q.aluop;
    assign do_memload  = strobes_q.memload;
    assign do_memstore = strobes_q.memstore;
    assign do_regstore = strobes_q.regstore;
    assign do_next     = strobes_q.next;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (default parameters).
module tb_exec_sequencer;

    localparam logic [3:0] OP_LOADLO = 4'h1;
    localparam logic [3:0] OP_JMP    = 4'h2;
    localparam logic [3:0] OP_BR     = 4'h3;
    localparam logic [3:0] OP_IN     = 4'h4;
    localparam logic [3:0] OP_OUT    = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [3:0] OP_ILLEGAL = 4'h9;

    // Strobe vector order: fetch, regload, aluop, memload, memstore, regstore, next
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_F    = 7'b1000000;
    localparam logic [6:0] S_RL   = 7'b0100000;
    localparam logic [6:0] S_AL   = 7'b0010000;
    localparam logic [6:0] S_ML   = 7'b0001000;
    localparam logic [6:0] S_MS   = 7'b0000100;
    localparam logic [6:0] S_RS   = 7'b0000010;
    localparam logic [6:0] S_NX   = 7'b0000001;

    logic        clk = 1'b0;
    logic        do_reset = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        isaluop = 1'b0;
    logic [7:0]  bigval = 8'h00;
    logic [15:0] cond_val = 16'h0000;
    logic        fetch_ack = 1'b0;
    logic        port_ack = 1'b0;
    logic [15:0] pointer;
    logic        do_fetch, do_regload, do_aluop, do_memload, do_memstore, do_regstore, do_next;
    logic        halted, fault;

    int n_tests = 0;
    int n_fail  = 0;

    exec_sequencer dut (
        .clk         (clk),
        .do_reset    (do_reset),
        .opcode      (opcode),
        .isaluop     (isaluop),
        .bigval      (bigval),
        .cond_val    (cond_val),
        .fetch_ack   (fetch_ack),
        .port_ack    (port_ack),
        .pointer     (pointer),
        .do_fetch    (do_fetch),
        .do_regload  (do_regload),
        .do_aluop    (do_aluop),
        .do_memload  (do_memload),
        .do_memstore (do_memstore),
        .do_regstore (do_regstore),
        .do_next     (do_next),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] stb();
        return {do_fetch, do_regload, do_aluop, do_memload, do_memstore, do_regstore, do_next};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        do_reset = 1'b1;
        @(negedge clk);
        do_reset = 1'b0;
    endtask

    // Present an instruction word with fetch_ack for one cycle, then scrub it.
    task automatic issue(input logic [3:0] op, input logic alu, input logic [7:0] bv);
        opcode = op; isaluop = alu; bigval = bv; fetch_ack = 1'b1;
        @(negedge clk);
        opcode = 4'h0; isaluop = 1'b0; bigval = 8'h00; fetch_ack = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (stb() !== S_NONE) begin n_fail++; $display("FAIL reset_strobes: got %b want %b", stb(), S_NONE); end
        n_tests++;
        if (pointer !== 16'h0000) begin n_fail++; $display("FAIL reset_pointer: got %h want 0000", pointer); end
        n_tests++;
        if (halted !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got halted=%b fault=%b want 0 0", halted, fault); end
        cyc();
        n_tests++;
        if (stb() !== S_F) begin n_fail++; $display("FAIL reset_first_fetch: got %b want %b", stb(), S_F); end
    endtask

    task automatic test_alu();
        logic [6:0] exp_seq [5];
        exp_seq = '{S_RL, S_AL, S_RS, S_NX, S_F};
        opcode = 4'h0; isaluop = 1'b1; fetch_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            fetch_ack = 1'b0; isaluop = 1'b0;
            n_tests++;
            if (stb() !== exp_seq[i]) begin n_fail++; $display("FAIL alu_seq[%0d]: got %b want %b", i, stb(), exp_seq[i]); end
        end
        n_tests++;
        if (pointer !== 16'h0001) begin n_fail++; $display("FAIL alu_pointer: got %h want 0001", pointer); end
    endtask

    task automatic test_jump();
        apply_reset(); cyc();
        issue(OP_JMP, 1'b0, 8'h10);
        n_tests++;
        if (stb() !== S_NX || pointer !== 16'h0000) begin n_fail++; $display("FAIL jmp_next: got %b ptr %h want %b ptr 0000", stb(), pointer, S_NX); end
        cyc();
        n_tests++;
        if (pointer !== 16'h0010) begin n_fail++; $display("FAIL jmp_fwd: got %h want 0010", pointer); end
        issue(OP_JMP, 1'b0, 8'hFE); cyc();
        n_tests++;
        if (pointer !== 16'h000E) begin n_fail++; $display("FAIL jmp_back: got %h want 000E", pointer); end
        apply_reset(); cyc();
        issue(OP_JMP, 1'b0, 8'hFF); cyc();
        n_tests++;
        if (pointer !== 16'hFFFF) begin n_fail++; $display("FAIL jmp_underflow: got %h want FFFF", pointer); end
        issue(OP_JMP, 1'b0, 8'h02); cyc();
        n_tests++;
        if (pointer !== 16'h0001 || stb() !== S_F) begin n_fail++; $display("FAIL jmp_wrap: got %h %b want 0001 %b", pointer, stb(), S_F); end
    endtask

    task automatic test_branch();
        cond_val = 16'h0000;
        issue(OP_BR, 1'b0, 8'h05);
        n_tests++;
        if (stb() !== S_RL) begin n_fail++; $display("FAIL br_regload: got %b want %b", stb(), S_RL); end
        cyc();
        n_tests++;
        if (stb() !== S_NX) begin n_fail++; $display("FAIL br_next: got %b want %b", stb(), S_NX); end
        cyc();
        n_tests++;
        if (pointer !== 16'h0002) begin n_fail++; $display("FAIL br_not_taken: got %h want 0002", pointer); end
        cond_val = 16'h0001;
        issue(OP_BR, 1'b0, 8'h05); cyc(); cyc();
        n_tests++;
        if (pointer !== 16'h0007 || stb() !== S_F) begin n_fail++; $display("FAIL br_taken: got %h %b want 0007 %b", pointer, stb(), S_F); end
        cond_val = 16'h0000;
    endtask

    task automatic test_in_wait();
        int n;
        issue(OP_IN, 1'b0, 8'h00);
        n_tests++;
        if (stb() !== S_RL) begin n_fail++; $display("FAIL in_regload: got %b want %b", stb(), S_RL); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (stb() !== S_ML) begin n_fail++; $display("FAIL in_memload[%0d]: got %b want %b", i, stb(), S_ML); end
            if (i == 3) port_ack = 1'b1;
            cyc();
        end
        port_ack = 1'b0;
        n_tests++;
        if (stb() !== S_RS) begin n_fail++; $display("FAIL in_regstore: got %b want %b", stb(), S_RS); end
        cyc();
        n_tests++;
        if (stb() !== S_NX) begin n_fail++; $display("FAIL in_next: got %b want %b", stb(), S_NX); end
        cyc();
        n_tests++;
        if (pointer !== 16'h0008 || stb() !== S_F) begin n_fail++; $display("FAIL in_done: got %h %b want 0008 %b", pointer, stb(), S_F); end
        // Port never acknowledges: expect a timeout into FAULT.
        issue(OP_IN, 1'b0, 8'h00); cyc();
        n = 0;
        while (stb() === S_ML && n < 40) begin n++; cyc(); end
        n_tests++;
        if (n !== 16) begin n_fail++; $display("FAIL in_timeout_cycles: got %0d want 16", n); end
        n_tests++;
        if (fault !== 1'b1 || stb() !== S_NONE || pointer !== 16'h0008) begin n_fail++; $display("FAIL in_timeout_fault: got fault=%b %b ptr %h want 1 %b 0008", fault, stb(), pointer, S_NONE); end
        port_ack = 1'b1; fetch_ack = 1'b1; cyc(); cyc();
        port_ack = 1'b0; fetch_ack = 1'b0;
        n_tests++;
        if (fault !== 1'b1 || pointer !== 16'h0008) begin n_fail++; $display("FAIL fault_sticky: got fault=%b ptr %h want 1 0008", fault, pointer); end
    endtask

    task automatic test_fetch_limit();
        apply_reset(); cyc();
        for (int i = 0; i < 15; i++) begin
            n_tests++;
            if (stb() !== S_F) begin n_fail++; $display("FAIL fetch_wait[%0d]: got %b want %b", i, stb(), S_F); end
            cyc();
        end
        issue(OP_JMP, 1'b0, 8'h01);
        n_tests++;
        if (stb() !== S_NX || fault !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_at_limit: got %b fault=%b want %b 0", stb(), fault, S_NX); end
        cyc();
        n_tests++;
        if (pointer !== 16'h0001) begin n_fail++; $display("FAIL fetch_limit_ptr: got %h want 0001", pointer); end
    endtask

    task automatic test_halt_illegal();
        apply_reset(); cyc();
        issue(OP_LOADLO, 1'b0, 8'h00);
        n_tests++;
        if (stb() !== S_RS) begin n_fail++; $display("FAIL loadlo_regstore: got %b want %b", stb(), S_RS); end
        cyc(); cyc();
        issue(OP_HALT, 1'b0, 8'h00);
        n_tests++;
        if (halted !== 1'b1 || stb() !== S_NONE) begin n_fail++; $display("FAIL halt_enter: got halted=%b %b want 1 %b", halted, stb(), S_NONE); end
        for (int i = 0; i < 20; i++) begin
            fetch_ack = i[0]; port_ack = ~i[0];
            cyc();
            n_tests++;
            if (halted !== 1'b1 || stb() !== S_NONE || pointer !== 16'h0001) begin n_fail++; $display("FAIL halt_hold[%0d]: got halted=%b %b ptr %h want 1 %b 0001", i, halted, stb(), pointer, S_NONE); end
        end
        fetch_ack = 1'b0; port_ack = 1'b0;
        apply_reset();
        n_tests++;
        if (halted !== 1'b0 || pointer !== 16'h0000 || stb() !== S_NONE) begin n_fail++; $display("FAIL halt_reset: got halted=%b ptr %h %b want 0 0000 %b", halted, pointer, stb(), S_NONE); end
        cyc();
        n_tests++;
        if (stb() !== S_F) begin n_fail++; $display("FAIL halt_reset_fetch: got %b want %b", stb(), S_F); end
        issue(OP_ILLEGAL, 1'b0, 8'h00);
        n_tests++;
        if (fault !== 1'b1 || stb() !== S_NONE) begin n_fail++; $display("FAIL illegal_fault: got fault=%b %b want 1 %b", fault, stb(), S_NONE); end
        apply_reset();
        n_tests++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_reset: got %b want 0", fault); end
    endtask

    task automatic test_reset_memstore();
        cyc();
        issue(OP_JMP, 1'b0, 8'h03); cyc();
        n_tests++;
        if (pointer !== 16'h0003) begin n_fail++; $display("FAIL ms_pre_ptr: got %h want 0003", pointer); end
        issue(OP_OUT, 1'b0, 8'h00); cyc();
        n_tests++;
        if (stb() !== S_MS) begin n_fail++; $display("FAIL ms_enter: got %b want %b", stb(), S_MS); end
        cyc();
        do_reset = 1'b1; port_ack = 1'b1;
        cyc();
        do_reset = 1'b0; port_ack = 1'b0;
        n_tests++;
        if (stb() !== S_NONE || pointer !== 16'h0000) begin n_fail++; $display("FAIL ms_reset: got %b ptr %h want %b 0000", stb(), pointer, S_NONE); end
        cyc();
        n_tests++;
        if (stb() !== S_F || pointer !== 16'h0000) begin n_fail++; $display("FAIL ms_reset_fetch: got %b ptr %h want %b 0000", stb(), pointer, S_F); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_jump();
        test_branch();
        test_in_wait();
        test_fetch_limit();
        test_halt_illegal();
        test_reset_memstore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
